// File: rtl/nn_pkg.sv
// Shared constants and types for the inference datapath image store.
package nn_pkg;

    localparam int unsigned IMG_PIXELS = 784;
    localparam int unsigned IMG_PIX_W  = 8;
    localparam int unsigned NN_DATA_W  = 32;

    typedef logic [NN_DATA_W-1:0] pix_word_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

    localparam int unsigned IMG_ADDR_W = addr_bits(IMG_PIXELS);

endpackage

// File: rtl/image_frame_buffer_if.sv
// Loader / consumer bus of the ping-pong image frame buffer.
interface image_frame_buffer_if
    import nn_pkg::*;
#(
    parameter int unsigned PIX_W  = IMG_PIX_W,
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned ADDR_W = 16
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [PIX_W-1:0]  wr_pixel;
    logic              frame_valid;
    logic              frame_release;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_valid, wr_pixel, frame_release, rd_en, rd_addr,
        input  wr_ready, frame_valid, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_pixel, frame_release, rd_en, rd_addr,
        output wr_ready, frame_valid, rd_data, rd_valid
    );

endinterface

// File: rtl/image_frame_buffer_ram.sv
// img_bank_ram: one image bank, synchronous write and registered read.
module img_bank_ram #(
    parameter int unsigned DEPTH = 784,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/image_frame_buffer.sv
// Double-buffered image store: pixel stream in, addressed 1-cycle reads out.
// Optional IMG_BINARIZE_EN stores 1 bit per pixel (pixel >= THRESH).
module image_frame_buffer
    import nn_pkg::*;
#(
    parameter int unsigned PIXELS = IMG_PIXELS,
    parameter int unsigned PIX_W  = IMG_PIX_W,
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned THRESH = 128
) (
    input logic                 clk,
    input logic                 reset,
    image_frame_buffer_if.slave bus
);

    localparam int unsigned RAM_AW = addr_bits(PIXELS);
`ifdef IMG_BINARIZE_EN
    localparam int unsigned STORE_W = 1;
`else
    localparam int unsigned STORE_W = PIX_W;
`endif
    localparam logic [RAM_AW-1:0] LAST_CNT  = RAM_AW'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    if (PIX_W > DATA_W) begin : g_bad_pix_w
        $error("image_frame_buffer: PIX_W must not exceed DATA_W");
    end
    if (PIXELS < 2 || (64'd1 << ADDR_W) < 64'(PIXELS)) begin : g_bad_addr_w
        $error("image_frame_buffer: ADDR_W too small for PIXELS");
    end
    if (THRESH >= (64'd1 << PIX_W)) begin : g_bad_thresh
        $error("image_frame_buffer: THRESH not representable in PIX_W bits");
    end

    bank_t              wr_bank;
    bank_t              rd_bank;
    bank_t              rd_sel_q;
    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic [RAM_AW-1:0]  wr_cnt;
    logic               wr_fire;
    logic               wr_last;
    logic               rel_fire;
    logic               rd_in_range;
    logic               rd_read;
    logic               oob_q;
    logic               rd_valid_q;
    logic [STORE_W-1:0] wdata;
    logic [STORE_W-1:0] bank_rdata [2];

    assign bus.wr_ready    = !full[wr_bank];
    assign bus.frame_valid = full[rd_bank];
    assign bus.rd_valid    = rd_valid_q;

    assign wr_fire     = bus.wr_valid && bus.wr_ready;
    assign wr_last     = (wr_cnt == LAST_CNT);
    assign rel_fire    = bus.frame_release && bus.frame_valid;
    assign rd_in_range = (bus.rd_addr <= LAST_ADDR);
    assign rd_read     = bus.rd_en && rd_in_range;

`ifdef IMG_BINARIZE_EN
    assign wdata = (bus.wr_pixel >= PIX_W'(THRESH));
`else
    assign wdata = bus.wr_pixel;
`endif

    // Both banks read every in-range request; the bank registered with the
    // request picks the result, so a same-cycle release cannot redirect it.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        img_bank_ram #(
            .DEPTH (PIXELS),
            .WIDTH (STORE_W),
            .AW    (RAM_AW)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (wr_fire && (wr_bank == ((b == 0) ? BANK0 : BANK1))),
            .waddr (wr_cnt),
            .wdata (wdata),
            .re    (rd_read),
            .raddr (bus.rd_addr[RAM_AW-1:0]),
            .rdata (bank_rdata[b])
        );
    end

    // Completion and release never target the same bank, so both apply.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rel_fire) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full    <= '0;
            wr_bank <= BANK0;
            rd_bank <= BANK0;
            wr_cnt  <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= other_bank(wr_bank);
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rel_fire) begin
                rd_bank <= other_bank(rd_bank);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= BANK0;
            oob_q      <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_q <= rd_bank;
                oob_q    <= !rd_in_range;
            end
        end
    end

    assign bus.rd_data = oob_q ? '0 : DATA_W'(bank_rdata[rd_sel_q]);

endmodule

// File: tb/tb_image_frame_buffer.sv
// Self-checking bench for image_frame_buffer (scoreboard of read results).
module tb_image_frame_buffer;
    import nn_pkg::*;

    localparam int P = IMG_PIXELS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    image_frame_buffer_if #(.PIX_W(8), .DATA_W(32), .ADDR_W(16)) bus ();

    image_frame_buffer #(
        .PIXELS (P),
        .PIX_W  (8),
        .DATA_W (32),
        .ADDR_W (16),
        .THRESH (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: FIFO of up to two complete frames plus the frame being loaded.
    pix_word_t  exp_q[$];
    pix_word_t  last_data = '0;
    logic [7:0] mf [2][P];
    int         mhead  = 0;
    int         mcount = 0;
    int         wcnt   = 0;

    function automatic pix_word_t fmt(input logic [7:0] p);
`ifdef IMG_BINARIZE_EN
        return (p >= 8'd128) ? 32'd1 : 32'd0;
`else
        return {24'd0, p};
`endif
    endfunction

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return 8'(i % 256);
            1:       return 8'd3;
            2:       return 8'd7;
            3:       return 8'((i * 7 + 1) % 256);
            4:       return 8'(255 - (i % 256));
            default: return (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : 8'(i % 256);
        endcase
    endfunction

    task automatic idle();
        bus.wr_valid      = 1'b0;
        bus.wr_pixel      = '0;
        bus.frame_release = 1'b0;
        bus.rd_en         = 1'b0;
        bus.rd_addr       = '0;
    endtask

    task automatic drive_read(input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 16'(addr);
        if (addr < P) exp_q.push_back(fmt(mf[mhead][addr]));
        else          exp_q.push_back('0);
    endtask

    // One clock: update the reference from the inputs in force, then check.
    task automatic cycle();
        logic fire, rel, rd;
        logic [7:0] px;
        pix_word_t e;
        fire = bus.wr_valid && (mcount < 2);
        rel  = bus.frame_release && (mcount > 0);
        rd   = bus.rd_en;
        px   = bus.wr_pixel;
        @(posedge clk);
        #1;
        if (fire) begin
            mf[(mhead + mcount) % 2][wcnt] = px;
            wcnt++;
        end
        if (rel) begin
            mhead = (mhead + 1) % 2;
            mcount--;
        end
        if (fire && wcnt == P) begin
            wcnt = 0;
            mcount++;
        end
        checks++;
        if (bus.wr_ready !== (mcount < 2)) begin
            errors++;
            $display("FAIL wr_ready: got %b exp %b", bus.wr_ready, (mcount < 2));
        end
        checks++;
        if (bus.frame_valid !== (mcount > 0)) begin
            errors++;
            $display("FAIL frame_valid: got %b exp %b", bus.frame_valid, (mcount > 0));
        end
        if (rd) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: no expected read result queued");
            end else begin
                e = exp_q.pop_front();
                last_data = e;
                checks++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got valid=%b data=%h exp valid=1 data=%h",
                             bus.rd_valid, bus.rd_data, e);
                end
            end
        end else begin
            checks++;
            if (bus.rd_valid !== 1'b0 || bus.rd_data !== last_data) begin
                errors++;
                $display("FAIL rd_hold: got valid=%b data=%h exp valid=0 data=%h",
                         bus.rd_valid, bus.rd_data, last_data);
            end
        end
    endtask

    task automatic write_frame(input int kind);
        for (int i = 0; i < P; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_pixel = pat(kind, i);
            cycle();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_release();
        bus.frame_release = 1'b1;
        cycle();
        bus.frame_release = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.frame_valid !== 1'b0 ||
            bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got ready=%b fv=%b data=%h rv=%b exp 1 0 0 0",
                     bus.wr_ready, bus.frame_valid, bus.rd_data, bus.rd_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < P; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_pixel = pat(0, i);
            cycle();
            if (i == P - 2) begin
                checks++;
                if (bus.frame_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_valid_early: got %b exp 0", bus.frame_valid);
                end
            end
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL frame_valid_rise: got %b exp 1", bus.frame_valid);
        end
        drive_read(5);
        cycle();
        drive_read(300);
        cycle();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== fmt(8'd44)) begin
            errors++;
            $display("FAIL rd_addr_300: got %h exp %h", bus.rd_data, fmt(8'd44));
        end
        cycle();
        cycle();
        pulse_release();
    endtask

    task automatic test_back_to_back();
        write_frame(1);
        write_frame(2);
        checks++;
        if (bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_both_full: got %b exp 0", bus.wr_ready);
        end
        bus.wr_valid = 1'b1;
        bus.wr_pixel = 8'hEE;
        for (int i = 0; i < 3; i++) cycle();
        bus.wr_valid = 1'b0;
        drive_read(0);   cycle();
        drive_read(400); cycle();
        drive_read(783); cycle();
        // read issued with the release sees the old frame
        drive_read(10);
        bus.frame_release = 1'b1;
        cycle();
        bus.frame_release = 1'b0;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.rd_data !== fmt(8'd3)) begin
            errors++;
            $display("FAIL release_switch: got ready=%b data=%h exp 1 %h",
                     bus.wr_ready, bus.rd_data, fmt(8'd3));
        end
        drive_read(10);
        cycle();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== fmt(8'd7)) begin
            errors++;
            $display("FAIL second_frame: got %h exp %h", bus.rd_data, fmt(8'd7));
        end
        cycle();
        pulse_release();
    endtask

    task automatic test_coincide();
        write_frame(3);
        for (int i = 0; i < P; i++) begin
            bus.wr_valid      = 1'b1;
            bus.wr_pixel      = pat(4, i);
            bus.frame_release = (i == P - 1);
            cycle();
        end
        bus.frame_release = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL coincide_flags: got fv=%b ready=%b exp 1 1",
                     bus.frame_valid, bus.wr_ready);
        end
        bus.wr_pixel = 8'hAB;
        cycle();
        for (int i = 1; i < P; i++) begin
            bus.wr_pixel = pat(0, i);
            cycle();
        end
        bus.wr_valid = 1'b0;
        drive_read(0);     cycle();
        drive_read(1);     cycle();
        drive_read(P - 1); cycle();
        bus.rd_en = 1'b0;
        pulse_release();
        drive_read(0); cycle();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== fmt(8'hAB)) begin
            errors++;
            $display("FAIL new_frame_pixel0: got %h exp %h", bus.rd_data, fmt(8'hAB));
        end
        drive_read(1); cycle();
        bus.rd_en = 1'b0;
        pulse_release();
    endtask

    task automatic test_random_valid();
        int n = 0;
        while (mcount == 0 && n < 4 * P) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_pixel = 8'($urandom);
            cycle();
            n++;
        end
        bus.wr_valid = 1'b0;
        if (mcount == 0) begin
            errors++;
            $display("FAIL random_load_timeout: got %0d beats exp %0d", wcnt, P);
        end
        for (int a = 0; a < P; a++) begin
            drive_read(a);
            cycle();
        end
        drive_read(784);   cycle();
        drive_read(65535); cycle();
        bus.rd_en = 1'b0;
        cycle();
        pulse_release();
    endtask

    task automatic test_reset_mid();
        write_frame(0);
        for (int i = 0; i < 400; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_pixel = pat(4, i);
            cycle();
        end
        idle();
        reset = 1'b1;
        #1;
        mcount = 0; mhead = 0; wcnt = 0; last_data = '0;
        exp_q.delete();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.wr_ready !== 1'b1 ||
            bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got fv=%b ready=%b rv=%b data=%h exp 0 1 0 0",
                     bus.frame_valid, bus.wr_ready, bus.rd_valid, bus.rd_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        write_frame(4);
        drive_read(0);   cycle();
        drive_read(399); cycle();
        drive_read(400); cycle();
        drive_read(783); cycle();
        bus.rd_en = 1'b0;
        pulse_release();
    endtask

    task automatic test_binarize();
        write_frame(5);
        drive_read(0); cycle();
        checks++;
        if (bus.rd_data !== fmt(8'd127)) begin
            errors++;
            $display("FAIL pixel_127: got %h exp %h", bus.rd_data, fmt(8'd127));
        end
        drive_read(1); cycle();
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== fmt(8'd128)) begin
            errors++;
            $display("FAIL pixel_128: got %h exp %h", bus.rd_data, fmt(8'd128));
        end
        cycle();
        pulse_release();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_coincide();
        test_random_valid();
        test_reset_mid();
        test_binarize();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
